// File: rtl/deb_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state codes and
// the counter width helper.
package deb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE         = 2'd0;
  localparam state_t ST_PRESS_WAIT   = 2'd1;
  localparam state_t ST_HELD         = 2'd2;
  localparam state_t ST_RELEASE_WAIT = 2'd3;

  // Bits needed to hold max(deb, lng) without overflow.
  function automatic int cnt_width(input int deb, input int lng);
    int m;
    m = (lng > deb) ? lng : deb;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/deb_chan.sv
// One debounce channel: 2-flop synchroniser, lockout/hold counter and the
// press / release / long-press event FSM. All outputs are registered.
module deb_chan
  import deb_pkg::*;
#(
  parameter int DEB_COUNT  = 2000000,
  parameter int LONG_COUNT = 24000000
) (
  input  logic clk,
  input  logic nrst,
  input  logic nbtn,
  output logic press,
  output logic rel,
  output logic long_press,
  output logic level
);

  localparam int                CNT_W    = cnt_width(DEB_COUNT, LONG_COUNT);
  localparam bit                LONG_EN  = (LONG_COUNT != 0);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_COUNT - 1);
  // Held count stops here so the long-press compare can never re-match.
  localparam logic [CNT_W-1:0]  CNT_SAT  = LONG_EN ? CNT_W'(LONG_COUNT - 1) : DEB_LAST;
  // Long-press fires on the edge that advances cnt to LONG_COUNT-1.
  localparam logic [CNT_W-1:0]  LONG_PRE = LONG_EN ? CNT_W'(LONG_COUNT - 2) : '0;

  logic [1:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             level_q, level_d;

  logic             btn_s;
  logic [CNT_W-1:0] cnt_inc;
  logic             long_hit;

  assign btn_s = sync_q[1];

  // Next-state: synchroniser shift, FSM transitions, counter and event pulses.
  always_comb begin
    sync_d   = {sync_q[0], ~nbtn};
    state_d  = state_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    long_hit = LONG_EN && (cnt_q == LONG_PRE);
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      ST_PRESS_WAIT: begin
        // Input ignored while bounce settles.
        cnt_d  = cnt_inc;
        long_d = long_hit;
        if (cnt_q == DEB_LAST) state_d = ST_HELD;
      end
      ST_HELD: begin
        cnt_d  = cnt_inc;
        long_d = long_hit;
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_PRESS_WAIT) || (state_d == ST_HELD);
  end

  // All channel state, async clear to released/idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      level_q <= level_d;
    end
  end

  assign press      = press_q;
  assign rel        = rel_q;
  assign long_press = long_q;
  assign level      = level_q;

endmodule

// File: rtl/deb_multi.sv
// Multi-channel push-button debouncer: NUM_CH independent deb_chan instances.
// The release event port is named rel (release is a reserved word).
module deb_multi
  import deb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEB_COUNT  = 2000000,
  parameter int LONG_COUNT = 24000000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_CH-1:0] nbtn,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] rel,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] level
);

  // Elaboration-time parameter legality.
  if (NUM_CH < 1) begin : g_bad_ch
    $error("deb_multi: NUM_CH must be >= 1");
  end
  if (DEB_COUNT < 2) begin : g_bad_deb
    $error("deb_multi: DEB_COUNT must be >= 2");
  end
  if (LONG_COUNT != 0 && LONG_COUNT <= DEB_COUNT) begin : g_bad_long
    $error("deb_multi: LONG_COUNT must be 0 or > DEB_COUNT");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    deb_chan #(
      .DEB_COUNT (DEB_COUNT),
      .LONG_COUNT(LONG_COUNT)
    ) u_chan (
      .clk       (clk),
      .nrst      (nrst),
      .nbtn      (nbtn[g]),
      .press     (press[g]),
      .rel       (rel[g]),
      .long_press(long_press[g]),
      .level     (level[g])
    );
  end

endmodule
